keypad_hex_entry: RTL and testbench

KEYPAD_HEX_ENTRY -- requirements
Module: keypad_hex_entry

---
 rtl/keypad_hex_entry.sv | 186 ++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with debounce that shifts each accepted hex key
// into a 32-bit number for an 8-digit hex display.
module keypad_hex_entry #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic        clk_keypad,
   input  logic        reset,
   input  logic        power_on,
   input  logic        clear,
   input  logic [3:0]  FILA,
   output logic [3:0]  COLUMNA,
   output logic [31:0] numero_salida,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [3:0]  digit_count,
   output logic [2:0]  state_dbg_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_DEBOUNCE = 3'd2,
      ST_HELD     = 3'd3,
      ST_RELEASE  = 3'd4
   } state_t;

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_DONE   = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   state_t          state_q;
   logic [3:0]      rs_meta_q;
   logic [3:0]      rs_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      col_q;
   logic [3:0]      pat_q;
   logic [3:0]      columna_q;
   logic [31:0]     numero_q;
   logic [3:0]      key_code_q;
   logic            key_valid_q;
   logic [3:0]      count_q;
   logic [3:0]      key_d;
   logic [1:0]      next_col_d;

   function automatic logic [1:0] row_idx(input logic [3:0] pat);
      case (pat)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'b0000: key_map = 4'h1;
         4'b0001: key_map = 4'h2;
         4'b0010: key_map = 4'h3;
         4'b0011: key_map = 4'hA;
         4'b0100: key_map = 4'h4;
         4'b0101: key_map = 4'h5;
         4'b0110: key_map = 4'h6;
         4'b0111: key_map = 4'hB;
         4'b1000: key_map = 4'h7;
         4'b1001: key_map = 4'h8;
         4'b1010: key_map = 4'h9;
         4'b1011: key_map = 4'hC;
         4'b1100: key_map = 4'hE;
         4'b1101: key_map = 4'h0;
         4'b1110: key_map = 4'hF;
         default: key_map = 4'hD;
      endcase
   endfunction

   function automatic logic [3:0] col_strobe(input logic [1:0] c);
      col_strobe = ~(4'b0001 << c);
   endfunction

   always_comb begin
      key_d      = key_map(row_idx(pat_q), col_q);
      next_col_d = col_q + 2'd1;
   end

   always_ff @(posedge clk_keypad) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rs_meta_q   <= 4'hF;
         rs_q        <= 4'hF;
         cnt_q       <= '0;
         col_q       <= 2'd0;
         pat_q       <= 4'hF;
         columna_q   <= 4'hF;
         numero_q    <= 32'h0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         count_q     <= 4'd0;
      end else begin
         rs_meta_q   <= FILA;
         rs_q        <= rs_meta_q;
         key_valid_q <= 1'b0;
         if (!power_on) begin
            state_q   <= ST_IDLE;
            columna_q <= 4'hF;
            cnt_q     <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q   <= ST_SCAN;
                  col_q     <= 2'd0;
                  cnt_q     <= '0;
                  columna_q <= col_strobe(2'd0);
               end
               ST_SCAN: begin
                  if (cnt_q == DWELL_LAST) begin
                     cnt_q <= '0;
                     // Only a single low row is a valid press; none or several means keep scanning.
                     if ($countones(~rs_q) == 1) begin
                        pat_q   <= rs_q;
                        state_q <= ST_DEBOUNCE;
                     end else begin
                        col_q     <= next_col_d;
                        columna_q <= col_strobe(next_col_d);
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               ST_DEBOUNCE: begin
                  if (cnt_q == DEB_DONE) begin
                     key_valid_q <= 1'b1;
                     key_code_q  <= key_d;
                     numero_q    <= {numero_q[27:0], key_d};
                     if (count_q != 4'd8) count_q <= count_q + 4'd1;
                     state_q     <= ST_HELD;
                  end else if (rs_q == pat_q) begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end else begin
                     state_q   <= ST_SCAN;
                     cnt_q     <= '0;
                     col_q     <= next_col_d;
                     columna_q <= col_strobe(next_col_d);
                  end
               end
               ST_HELD: begin
                  if (rs_q == 4'hF) begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= '0;
                  end
               end
               ST_RELEASE: begin
                  if (rs_q != 4'hF) begin
                     state_q <= ST_HELD;
                  end else if (cnt_q == DEB_DONE) begin
                     state_q   <= ST_SCAN;
                     cnt_q     <= '0;
                     col_q     <= next_col_d;
                     columna_q <= col_strobe(next_col_d);
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q   <= ST_IDLE;
                  columna_q <= 4'hF;
               end
            endcase
         end
         // Clear overrides any same-cycle key update of the number and count.
         if (clear) begin
            numero_q <= 32'h0;
            count_q  <= 4'd0;
         end
      end
   end

   assign COLUMNA       = columna_q;
   assign numero_salida = numero_q;
   assign key_code      = key_code_q;
   assign key_valid     = key_valid_q;
   assign digit_count   = count_q;
   assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a behavioural keypad matrix model
// (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
module tb_keypad_hex_entry;

   localparam int SD = 4;
   localparam int DB = 8;
   localparam logic [2:0] S_IDLE = 3'd0, S_DEB = 3'd2, S_HELD = 3'd3;

   logic        clk = 1'b0;
   logic        reset, power_on, clear;
   logic [3:0]  fila, columna, key_code, digit_count;
   logic [31:0] numero;
   logic        key_valid;
   logic [2:0]  state_dbg;
   logic [3:0]  mask [4];
   int          checks = 0;
   int          errors = 0;
   int          kv_cnt = 0;

   keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk_keypad(clk), .reset(reset), .power_on(power_on), .clear(clear),
      .FILA(fila), .COLUMNA(columna), .numero_salida(numero), .key_code(key_code),
      .key_valid(key_valid), .digit_count(digit_count), .state_dbg_o(state_dbg)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed switch pulls its row low while its column is strobed.
   always_comb begin
      fila = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!columna[c]) fila = fila & ~mask[c];
   end

   always @(posedge clk) begin
      #1;
      if (key_valid === 1'b1) kv_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit, input string nm);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (state_dbg === st) break;
      end
      checks++;
      if (i == limit) begin
         errors++;
         $display("FAIL %s timeout waiting for state %0d, got %0d", nm, st, state_dbg);
      end
   endtask

   task automatic press_key(input int r, input int c, input int hold);
      mask[c][r] = 1'b1;
      cyc(hold);
      mask[c][r] = 1'b0;
      cyc(30);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(1);
   endtask

   task automatic test_reset();
      reset = 1'b1; power_on = 1'b0; clear = 1'b0;
      for (int c = 0; c < 4; c++) mask[c] = 4'h0;
      cyc(3);
      checks++; if (columna !== 4'hF) begin errors++; $display("FAIL reset_columna got %h exp f", columna); end
      checks++; if (numero !== 32'h0) begin errors++; $display("FAIL reset_numero got %h exp 0", numero); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code got %h exp 0", key_code); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
      checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", digit_count); end
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
      reset = 1'b0; power_on = 1'b1;
      cyc(2);
      checks++; if (columna !== 4'b1110) begin errors++; $display("FAIL power_on_col0 got %b exp 1110", columna); end
   endtask

   task automatic test_single();
      int kv0 = kv_cnt;
      press_key(1, 2, 40);
      checks++; if (kv_cnt - kv0 != 1) begin errors++; $display("FAIL single_kv_count got %0d exp 1", kv_cnt - kv0); end
      checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_key_code got %h exp 6", key_code); end
      checks++; if (numero !== 32'h6) begin errors++; $display("FAIL single_numero got %h exp 00000006", numero); end
      checks++; if (digit_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", digit_count); end
   endtask

   task automatic test_bounce();
      int kv0;
      pulse_clear();
      kv0 = kv_cnt;
      for (int i = 0; i < 10; i++) begin
         mask[0][0] = ~mask[0][0];
         cyc(3);
      end
      mask[0][0] = 1'b1;
      cyc(40);
      mask[0][0] = 1'b0;
      cyc(30);
      checks++; if (kv_cnt - kv0 != 1) begin errors++; $display("FAIL bounce_kv_count got %0d exp 1", kv_cnt - kv0); end
      checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL bounce_key_code got %h exp 1", key_code); end
      checks++; if (numero !== 32'h1) begin errors++; $display("FAIL bounce_numero got %h exp 00000001", numero); end
   endtask

   task automatic test_overflow();
      pulse_clear();
      for (int k = 0; k < 9; k++) begin
         press_key(k / 3, k % 3, 40);
         if (k == 7) begin
            checks++; if (numero !== 32'h12345678) begin errors++; $display("FAIL ovf_8_numero got %h exp 12345678", numero); end
            checks++; if (digit_count !== 4'd8) begin errors++; $display("FAIL ovf_8_count got %0d exp 8", digit_count); end
         end
      end
      checks++; if (numero !== 32'h23456789) begin errors++; $display("FAIL ovf_9_numero got %h exp 23456789", numero); end
      checks++; if (digit_count !== 4'd8) begin errors++; $display("FAIL ovf_9_count got %0d exp 8", digit_count); end
   endtask

   task automatic test_clear_collision();
      mask[3][2] = 1'b1;
      wait_state(S_DEB, 80, "collide_enter_debounce");
      cyc(DB);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL collide_early_kv got %b exp 0", key_valid); end
      clear = 1'b1;
      cyc(1);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL collide_latency_kv got %b exp 1", key_valid); end
      clear = 1'b0;
      checks++; if (numero !== 32'h0) begin errors++; $display("FAIL collide_numero got %h exp 0", numero); end
      checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL collide_count got %0d exp 0", digit_count); end
      checks++; if (key_code !== 4'hC) begin errors++; $display("FAIL collide_key_code got %h exp c", key_code); end
      mask[3][2] = 1'b0;
      cyc(30);
   endtask

   task automatic test_ghost();
      int kv0 = kv_cnt;
      logic [3:0] prev, exp_next;
      logic [3:0] seen = 4'h0;
      mask[1] = 4'b0101;
      prev = columna;
      for (int i = 0; i < 48; i++) begin
         cyc(1);
         if (columna !== prev) begin
            exp_next = {prev[2:0], prev[3]};
            checks++;
            if (columna !== exp_next) begin errors++; $display("FAIL ghost_col_step got %b exp %b", columna, exp_next); end
            prev = columna;
         end
         for (int c = 0; c < 4; c++) if (columna === ~(4'b0001 << c)) seen[c] = 1'b1;
      end
      checks++; if (seen !== 4'hF) begin errors++; $display("FAIL ghost_cols_seen got %b exp 1111", seen); end
      mask[1] = 4'h0;
      cyc(10);
      checks++; if (kv_cnt - kv0 != 0) begin errors++; $display("FAIL ghost_kv_count got %0d exp 0", kv_cnt - kv0); end
   endtask

   task automatic test_abort();
      int kv0;
      mask[1][1] = 1'b1;
      wait_state(S_HELD, 80, "abort_enter_held");
      kv0 = kv_cnt;
      checks++; if (numero !== 32'h5) begin errors++; $display("FAIL abort_pre_numero got %h exp 00000005", numero); end
      power_on = 1'b0;
      cyc(2);
      checks++; if (columna !== 4'hF) begin errors++; $display("FAIL abort_off_col got %b exp 1111", columna); end
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL abort_off_state got %0d exp 0", state_dbg); end
      mask[1][1] = 1'b0;
      cyc(20);
      checks++; if (columna !== 4'hF) begin errors++; $display("FAIL abort_off_col_late got %b exp 1111", columna); end
      power_on = 1'b1;
      cyc(40);
      checks++; if (kv_cnt - kv0 != 0) begin errors++; $display("FAIL abort_kv_count got %0d exp 0", kv_cnt - kv0); end
      checks++; if (numero !== 32'h5) begin errors++; $display("FAIL abort_numero got %h exp 00000005", numero); end
      checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL abort_key_code got %h exp 5", key_code); end
   endtask

   task automatic test_reset_mid();
      int kv0 = kv_cnt;
      mask[2][2] = 1'b1;
      wait_state(S_DEB, 80, "rstmid_enter_debounce");
      reset = 1'b1;
      cyc(1);
      mask[2][2] = 1'b0;
      checks++; if (columna !== 4'hF) begin errors++; $display("FAIL rstmid_col got %b exp 1111", columna); end
      checks++; if (numero !== 32'h0) begin errors++; $display("FAIL rstmid_numero got %h exp 0", numero); end
      cyc(1);
      reset = 1'b0;
      cyc(40);
      checks++; if (kv_cnt - kv0 != 0) begin errors++; $display("FAIL rstmid_kv_count got %0d exp 0", kv_cnt - kv0); end
      checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", digit_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounce();
      test_overflow();
      test_clear_collision();
      test_ghost();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
